adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one `two_comple_adder_16bit` instance between two requester ports.
  - Requesters are the ALU path and the address/branch-offset path.
  - Arbitration is round-robin, with a valid/ready handshake on each request port.
- Captures the selected operation's result and flags in a one-deep output register presented on a valid/ready response channel.
- Sits between the datapath operand muxes and the writeback stage of the multi-cycle RISC variant.

Parameters:
- RR_INIT, 0, port that holds priority after reset (0 or 1).
- FIXED_PRIO, 0, 1 = port 0 always wins (no rotation); 0 = round-robin.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  port 0 has an operation.
- req0_ready  output  1  port 0 operation accepted this cycle.
- req0_a  input  16  port 0 operand A.
- req0_b  input  16  port 0 operand B.
- req0_sub  input  1  port 0: 1 = A-B, 0 = A+B (drives adder C).
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as port 0, for port 1.
- rsp_valid  output  1  result register holds a result.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  port that issued the held result.
- rsp_y  output  16  adder Y.
- rsp_cout  output  1  adder Cout.
- rsp_ovf  output  1  signed overflow = Cout XOR Cout_1, where Cout_1 is the carry into bit 15.
- rsp_zero  output  1  rsp_y == 0.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs low, the priority pointer set to RR_INIT, and the stats counters cleared. A reset mid-operation drops any held result; it is not replayed.
- Free condition: out_free = !rsp_valid | rsp_ready.
- Grant (combinational):
  - Only one valid request: that port is granted.
  - Both valid: the pointer owner is granted; with FIXED_PRIO=1, port 0 is granted.
  - reqK_ready = out_free & grantK. At most one ready is high per cycle.
  - ready may depend combinationally on valid and rsp_ready. valid must not depend on ready.
- Adder operands are muxed from the granted port. With no grant, port 0's operands are driven; the result is unused.
- Handshake fire (reqK_valid & reqK_ready) in cycle N:
  - At the edge ending cycle N, Y, Cout, ovf, zero and id are captured, and rsp_valid=1 from cycle N+1.
  - Latency is exactly 1 cycle.
  - The pointer moves to the non-granted port. It does not move when no fire occurs.
- Output register states:
  - EMPTY (rsp_valid=0): a fire goes to FULL.
  - FULL with rsp_ready=0: hold; all rsp_* are stable and both readies are 0 (backpressure).
  - FULL with rsp_ready=1 and a new fire in the same cycle: the register is overwritten, rsp_valid stays 1, and full throughput of 1 op/cycle is sustained.
  - FULL with rsp_ready=1 and no fire: go to EMPTY.
- Requester rules:
  - A requester must hold valid and operands stable until ready.
  - Dropping valid without a handshake is permitted; the arbiter does not latch requests.
- Arithmetic: plain 16-bit two's complement. Cout is the raw adder carry, which for subtract means "no borrow". Wrap-around is unflagged except through rsp_ovf.
- Starvation bound: with both ports continuously valid, grants strictly alternate, so the wait is ≤1 grant (round-robin mode).

Optional Feature:
- Macro ADDER_SHARE_STATS_EN.
- Defined:
  - Extra outputs stat_gnt0 [15:0] and stat_gnt1 [15:0] count fires per port, saturating at 16'hFFFF.
  - Extra output stat_stall [15:0] counts cycles where some reqK_valid=1 and no fire occurred, also saturating.
  - All three are cleared by rst_n.
- Undefined: the ports and counters are absent; function is otherwise identical.

Test Plan:
1. Reset: hold rst_n=0 with random inputs → all outputs 0. Release; port 1 valid alone, a=16'h1234, b=16'h2345, sub=0 → req1_ready=1. Next cycle rsp_valid=1, rsp_id=1, rsp_y=16'h3579, rsp_cout=0, rsp_ovf=0.
2. Subtract: port 0 sends a=16'h1234, b=16'h2345, sub=1 → rsp_y=16'hEEEF, rsp_cout=0 (borrow), rsp_ovf=0. Then a=16'h2345, b=16'h2345, sub=1 → rsp_y=0, rsp_zero=1, rsp_cout=1.
3. Overflow: a=16'h7FFF, b=16'h0001, sub=0 → rsp_y=16'h8000, rsp_ovf=1, rsp_cout=0. Then a=16'h8000, b=16'h0001, sub=1 → rsp_y=16'h7FFF, rsp_ovf=1.
4. Contention: both ports valid for 6 cycles, rsp_ready=1, RR_INIT=0 → rsp_id sequence 0,1,0,1,0,1 and 1 op/cycle. Repeat with FIXED_PRIO=1 → all 0.
5. Backpressure: rsp_ready=0 for 4 cycles while both are valid → one result held stable, both readies 0. Then rsp_ready=1 → the next grant goes to the non-pointer-owner of the previous fire, with no result lost or duplicated.
6. Mid-operation reset: assert rst_n=0 asynchronously between edges while FULL → rsp_valid drops immediately; after release the pointer equals RR_INIT. With ADDER_SHARE_STATS_EN, counters read 0 and match fires/stalls after scenarios 4–5 (e.g. 3/3/0 for scenario 4).

Source files
------------

// File: rtl/adder_share_if.sv
// Request/response bundle for the shared two's-complement adder arbiter.
// master drives requests and consumes results; slave is the arbiter.
interface adder_share_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_sub;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_y;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic        rsp_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y,
    input  rsp_cout, rsp_ovf, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y,
    output rsp_cout, rsp_ovf, rsp_zero
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Two-port round-robin arbiter sharing one 16-bit adder, one-deep result reg.
// Optional per-port/stall counters under ADDER_SHARE_STATS_EN.
module two_comple_adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C,
  output logic [15:0] Y,
  output logic        Cout,
  output logic        Cout_1
);
  logic [15:0] w_b;
  logic [15:0] w_lo;
  logic [1:0]  w_hi;

  assign w_b  = B ^ {16{C}};
  assign w_lo = {1'b0, A[14:0]} + {1'b0, w_b[14:0]} + {15'd0, C};
  assign w_hi = {1'b0, A[15]} + {1'b0, w_b[15]} + {1'b0, w_lo[15]};
  assign Y      = {w_hi[0], w_lo[14:0]};
  assign Cout   = w_hi[1];
  assign Cout_1 = w_lo[15];
endmodule

module adder_share_arbiter #(
  parameter bit RR_INIT    = 1'b0,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  adder_share_if.slave bus
`ifdef ADDER_SHARE_STATS_EN
  ,
  output logic [15:0] stat_gnt0,
  output logic [15:0] stat_gnt1,
  output logic [15:0] stat_stall
`endif
);
  typedef enum logic {S_EMPTY, S_FULL} st_t;

  st_t         r_state;
  st_t         w_nstate;
  logic        r_ptr;
  logic [15:0] r_y;
  logic        r_cout;
  logic        r_ovf;
  logic        r_zero;
  logic        r_id;

  logic        w_free;
  logic        w_g0;
  logic        w_g1;
  logic        w_fire0;
  logic        w_fire1;
  logic        w_fire;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic        w_c;
  logic [15:0] w_y;
  logic        w_cout;
  logic        w_c15;

  // Readies are forced low while reset is held.
  assign w_free = rst_n & ((r_state == S_EMPTY) | bus.rsp_ready);

  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    unique case (1'b1)
      (bus.req0_valid & bus.req1_valid): begin
        if (FIXED_PRIO || !r_ptr) w_g0 = 1'b1;
        else                      w_g1 = 1'b1;
      end
      (bus.req0_valid & !bus.req1_valid): w_g0 = 1'b1;
      (!bus.req0_valid & bus.req1_valid): w_g1 = 1'b1;
      default: ;
    endcase
  end

  assign bus.req0_ready = w_free & w_g0;
  assign bus.req1_ready = w_free & w_g1;
  assign w_fire0 = bus.req0_valid & bus.req0_ready;
  assign w_fire1 = bus.req1_valid & bus.req1_ready;
  assign w_fire  = w_fire0 | w_fire1;

  assign w_a = w_g1 ? bus.req1_a   : bus.req0_a;
  assign w_b = w_g1 ? bus.req1_b   : bus.req0_b;
  assign w_c = w_g1 ? bus.req1_sub : bus.req0_sub;

  two_comple_adder_16bit u_add (
    .A      (w_a),
    .B      (w_b),
    .C      (w_c),
    .Y      (w_y),
    .Cout   (w_cout),
    .Cout_1 (w_c15)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_EMPTY: if (w_fire) w_nstate = S_FULL;
      S_FULL: begin
        if (w_fire)             w_nstate = S_FULL;
        else if (bus.rsp_ready) w_nstate = S_EMPTY;
      end
      default: w_nstate = S_EMPTY;
    endcase
  end

  always_comb begin
    bus.rsp_valid = (r_state == S_FULL);
    bus.rsp_id    = r_id;
    bus.rsp_y     = r_y;
    bus.rsp_cout  = r_cout;
    bus.rsp_ovf   = r_ovf;
    bus.rsp_zero  = r_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= RR_INIT;
      r_y    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_id   <= 1'b0;
    end else if (w_fire) begin
      r_ptr  <= ~w_fire1;
      r_y    <= w_y;
      r_cout <= w_cout;
      r_ovf  <= w_cout ^ w_c15;
      r_zero <= (w_y == 16'd0);
      r_id   <= w_fire1;
    end
  end

`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] r_gnt0;
  logic [15:0] r_gnt1;
  logic [15:0] r_stall;
  logic        w_stall;

  assign w_stall = (bus.req0_valid | bus.req1_valid) & !w_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt0  <= '0;
      r_gnt1  <= '0;
      r_stall <= '0;
    end else begin
      if (w_fire0 && r_gnt0 != 16'hFFFF)  r_gnt0  <= r_gnt0 + 16'd1;
      if (w_fire1 && r_gnt1 != 16'hFFFF)  r_gnt1  <= r_gnt1 + 16'd1;
      if (w_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end
  end

  assign stat_gnt0  = r_gnt0;
  assign stat_gnt1  = r_gnt1;
  assign stat_stall = r_stall;
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: round-robin and fixed-priority
// instances share the same request stimulus.
module tb_adder_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_share_if ifa ();
  adder_share_if ifb ();

  assign ifb.req0_valid = ifa.req0_valid;
  assign ifb.req0_a     = ifa.req0_a;
  assign ifb.req0_b     = ifa.req0_b;
  assign ifb.req0_sub   = ifa.req0_sub;
  assign ifb.req1_valid = ifa.req1_valid;
  assign ifb.req1_a     = ifa.req1_a;
  assign ifb.req1_b     = ifa.req1_b;
  assign ifb.req1_sub   = ifa.req1_sub;
  assign ifb.rsp_ready  = ifa.rsp_ready;

`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] a_g0, a_g1, a_st;
  logic [15:0] b_g0, b_g1, b_st;
`endif

  adder_share_arbiter #(.RR_INIT(1'b0), .FIXED_PRIO(1'b0)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
`ifdef ADDER_SHARE_STATS_EN
    ,
    .stat_gnt0  (a_g0),
    .stat_gnt1  (a_g1),
    .stat_stall (a_st)
`endif
  );

  adder_share_arbiter #(.RR_INIT(1'b0), .FIXED_PRIO(1'b1)) u_fx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
`ifdef ADDER_SHARE_STATS_EN
    ,
    .stat_gnt0  (b_g0),
    .stat_gnt1  (b_g1),
    .stat_stall (b_st)
`endif
  );

  typedef struct {
    bit          port;
    logic [15:0] a;
    logic [15:0] b;
    bit          sub;
    logic [15:0] y;
    bit          cout;
    bit          ovf;
    bit          zero;
  } vec_t;

  vec_t vt[7];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.req0_valid = 1'b0;
    ifa.req0_a = '0; ifa.req0_b = '0; ifa.req0_sub = 1'b0;
    ifa.req1_valid = 1'b0;
    ifa.req1_a = '0; ifa.req1_b = '0; ifa.req1_sub = 1'b0;
  endtask

  task automatic set_both();
    ifa.req0_a = 16'h0010; ifa.req0_b = 16'h0001; ifa.req0_sub = 1'b0;
    ifa.req1_a = 16'h0100; ifa.req1_b = 16'h0002; ifa.req1_sub = 1'b0;
    ifa.req0_valid = 1'b1;
    ifa.req1_valid = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{1'b1, 16'h1234, 16'h2345, 1'b0, 16'h3579, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 16'h1234, 16'h2345, 1'b1, 16'hEEEF, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 16'h2345, 16'h2345, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    ifa.rsp_ready = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ifa.req0_valid = 1'($urandom); ifa.req1_valid = 1'($urandom);
      ifa.req0_a = 16'($urandom); ifa.req0_b = 16'($urandom);
      ifa.req1_a = 16'($urandom); ifa.req1_b = 16'($urandom);
      ifa.req0_sub = 1'($urandom); ifa.req1_sub = 1'($urandom);
      ifa.rsp_ready = 1'($urandom);
      #3;
      chk("reset_outputs",
          {ifa.req0_ready, ifa.req1_ready, ifa.rsp_valid, ifa.rsp_id,
           ifa.rsp_y, ifa.rsp_cout, ifa.rsp_ovf, ifa.rsp_zero}, '0);
      tick();
    end
    idle_inputs();
    ifa.rsp_ready = 1'b1;
    rst_n = 1'b1;
    tick();

    // Single-port operations, one per cycle.
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      if (vt[i].port) begin
        ifa.req1_valid = 1'b1; ifa.req1_a = vt[i].a;
        ifa.req1_b = vt[i].b;  ifa.req1_sub = vt[i].sub;
      end else begin
        ifa.req0_valid = 1'b1; ifa.req0_a = vt[i].a;
        ifa.req0_b = vt[i].b;  ifa.req0_sub = vt[i].sub;
      end
      #1;
      chk($sformatf("vec%0d_ready", i),
          {ifa.req1_ready, ifa.req0_ready},
          vt[i].port ? 32'h2 : 32'h1);
      tick();
      idle_inputs();
      chk($sformatf("vec%0d_valid_id", i),
          {ifa.rsp_valid, ifa.rsp_id}, {1'b1, vt[i].port});
      chk($sformatf("vec%0d_y", i), ifa.rsp_y, vt[i].y);
      chk($sformatf("vec%0d_flags", i),
          {ifa.rsp_cout, ifa.rsp_ovf, ifa.rsp_zero},
          {vt[i].cout, vt[i].ovf, vt[i].zero});
    end
    tick();
    chk("drain_empty", ifa.rsp_valid, 1'b0);

    // Contention: fresh reset so the pointer starts at RR_INIT.
    pulse_reset();
    set_both();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_id%0d", i), {ifa.rsp_valid, ifa.rsp_id},
          {1'b1, 1'(i % 2)});
      chk($sformatf("rr_y%0d", i), ifa.rsp_y,
          (i % 2) ? 32'h0102 : 32'h0011);
      chk($sformatf("fx_id%0d", i), {ifb.rsp_valid, ifb.rsp_id}, 2'b10);
    end
    idle_inputs();
`ifdef ADDER_SHARE_STATS_EN
    chk("stats_contention", {a_g0, a_g1, a_st}, {16'd3, 16'd3, 16'd0});
    chk("stats_fixed", {b_g0, b_g1, b_st}, {16'd6, 16'd0, 16'd0});
`endif
    tick();
    chk("contention_drain", ifa.rsp_valid, 1'b0);

    // Backpressure with both ports requesting.
    set_both();
    ifa.rsp_ready = 1'b0;
    #1;
    chk("bp_first_ready", {ifa.req1_ready, ifa.req0_ready}, 2'b01);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_hold%0d_ready", k),
          {ifa.req1_ready, ifa.req0_ready}, 2'b00);
      chk($sformatf("bp_hold%0d_rsp", k),
          {ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y}, {1'b1, 1'b0, 16'h0011});
      tick();
    end
    ifa.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {ifa.req1_ready, ifa.req0_ready}, 2'b10);
    tick();
    idle_inputs();
    chk("bp_next_rsp", {ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y},
        {1'b1, 1'b1, 16'h0102});
    tick();
    chk("bp_no_dup", ifa.rsp_valid, 1'b0);
`ifdef ADDER_SHARE_STATS_EN
    chk("stats_backpressure", {a_g0, a_g1, a_st},
        {16'd4, 16'd4, 16'd4});
`endif

    // Mid-operation asynchronous reset while FULL.
    ifa.rsp_ready = 1'b0;
    ifa.req0_valid = 1'b1;
    ifa.req0_a = 16'h0005; ifa.req0_b = 16'h0006;
    tick();
    idle_inputs();
    chk("mid_full", {ifa.rsp_valid, ifa.rsp_y}, {1'b1, 16'h000B});
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_async_drop",
        {ifa.rsp_valid, ifa.rsp_id, ifa.rsp_y,
         ifa.rsp_cout, ifa.rsp_ovf, ifa.rsp_zero}, '0);
    #1;
    rst_n = 1'b1;
`ifdef ADDER_SHARE_STATS_EN
    chk("stats_cleared", {a_g0, a_g1, a_st}, '0);
`endif
    ifa.rsp_ready = 1'b1;
    set_both();
    #1;
    chk("ptr_after_reset", {ifa.req1_ready, ifa.req0_ready}, 2'b01);
    tick();
    idle_inputs();
    chk("ptr_after_reset_id", {ifa.rsp_valid, ifa.rsp_id}, 2'b10);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
